// File: rtl/bus_arbiter_if.sv
// Shared bus between the arbiter and its agents: per-agent bids and payloads
// going in, grant and the muxed owner payload coming out.
interface bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = 32
);
    localparam int unsigned OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [2*NUM_REQ-1:0]  req_i;
    logic [2*NUM_REQ-1:0]  len_i;
    logic [3*NUM_REQ-1:0]  cmd_i;
    logic [DW*NUM_REQ-1:0] addrdata_i;

    logic [NUM_REQ-1:0]    gnt_o;
    logic [OW-1:0]         owner_o;
    logic                  busy_o;
    logic                  phase_o;
    logic [2:0]            cmd_o;
    logic [1:0]            lenout_o;
    logic [DW-1:0]         addrdata_o;

    // Agent side: drives bids and payloads, observes grant and the shared bus.
    modport master (
        output req_i, len_i, cmd_i, addrdata_i,
        input  gnt_o, owner_o, busy_o, phase_o, cmd_o, lenout_o, addrdata_o
    );

    // Arbiter side.
    modport slave (
        input  req_i, len_i, cmd_i, addrdata_i,
        output gnt_o, owner_o, busy_o, phase_o, cmd_o, lenout_o, addrdata_o
    );
endinterface

// File: rtl/bus_arbiter.sv
// Priority arbiter with round-robin tie-break for a shared addr/data/cmd bus.
// Each grant is a fixed tenure: one address cycle followed by len+1 data beats.
// A new winner can be taken on the last data beat, giving zero-bubble tenures.
module bus_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = 32
) (
    input logic          clk,
    input logic          reset,
    bus_arbiter_if.slave bus
);
    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $fatal(1, "bus_arbiter: NUM_REQ must be in 2..8");
    end

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } state_e;

    state_e             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IW-1:0]      owner_q;
    logic [IW-1:0]      rr_ptr_q;
    logic [1:0]         len_q;
    logic [1:0]         beat_cnt_q;

    logic [1:0]         max_lvl;
    logic               any_req;
    logic               found;
    int unsigned        cand;
    logic [IW-1:0]      win_idx;
    logic [1:0]         win_len;
    logic               last_beat;
    logic               grant_now;
    logic [NUM_REQ-1:0] win_onehot;

    logic [2:0]         cmd_mux;
    logic [1:0]         len_mux;
    logic [DW-1:0]      ad_mux;

    // Winner: highest bid level, ties broken by scanning upward from rr_ptr+1.
    always_comb begin
        max_lvl = 2'b00;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (bus.req_i[2*i +: 2] > max_lvl) begin
                max_lvl = bus.req_i[2*i +: 2];
            end
        end
        any_req = (max_lvl != 2'b00);

        found   = 1'b0;
        cand    = 0;
        win_idx = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && bus.req_i[2*cand +: 2] == max_lvl) begin
                found   = 1'b1;
                win_idx = IW'(cand);
            end
        end
        win_len = bus.len_i[2*win_idx +: 2];

        for (int i = 0; i < int'(NUM_REQ); i++) begin
            win_onehot[i] = (win_idx == IW'(i));
        end
    end

    // Arbitration is only open while idle or on the closing data beat.
    always_comb begin
        last_beat = (state_q == StData) && (beat_cnt_q == len_q);
        grant_now = any_req && ((state_q == StIdle) || last_beat);
    end

    // Tenure FSM; grant, owner and latched length are all registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= IW'(NUM_REQ - 1);
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else if (grant_now) begin
            state_q    <= StAddr;
            gnt_q      <= win_onehot;
            owner_q    <= win_idx;
            rr_ptr_q   <= win_idx;
            len_q      <= win_len;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    gnt_q   <= '0;
                    owner_q <= '0;
                end
                StAddr: begin
                    state_q    <= StData;
                    beat_cnt_q <= '0;
                end
                StData: begin
                    if (last_beat) begin
                        state_q    <= StIdle;
                        gnt_q      <= '0;
                        owner_q    <= '0;
                        len_q      <= '0;
                        beat_cnt_q <= '0;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + 2'd1;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    gnt_q      <= '0;
                    owner_q    <= '0;
                    len_q      <= '0;
                    beat_cnt_q <= '0;
                end
            endcase
        end
    end

    // Owner payload mux; stays all-zero whenever nobody holds the grant.
    always_comb begin
        cmd_mux = '0;
        len_mux = '0;
        ad_mux  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_q[i]) begin
                cmd_mux = bus.cmd_i[3*i +: 3];
                ad_mux  = bus.addrdata_i[DW*i +: DW];
                len_mux = len_q;
            end
        end
    end

    assign bus.gnt_o      = gnt_q;
    assign bus.owner_o    = owner_q;
    assign bus.busy_o     = (state_q != StIdle);
    assign bus.phase_o    = (state_q == StData);
    assign bus.cmd_o      = cmd_mux;
    assign bus.lenout_o   = len_mux;
    assign bus.addrdata_o = ad_mux;

    // Grant is never multi-hot, and never asserted while idle.
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
    a_idle_no_gnt: assert property (@(posedge clk) disable iff (reset)
                                    (state_q == StIdle) |-> (gnt_q == '0));
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus random traffic, every cycle
// compared against a tenure-level model (position within tenure, last winner).
module tb_bus_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_arbiter_if #(.NUM_REQ(N), .DW(DW)) bus ();

    bus_arbiter #(.NUM_REQ(N), .DW(DW)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    logic [1:0]    req_v [N];
    logic [1:0]    len_v [N];
    logic [2:0]    cmd_v [N];
    logic [DW-1:0] ad_v  [N];

    // Model: tenure position 0 = address cycle, 1..len+1 = data beats.
    bit m_busy;
    int m_owner;
    int m_len;
    int m_pos;
    int m_last;

    int n_assert;
    int n_fail;
    int dut_grants[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            cmd_v[i] = 3'($urandom_range(0, 7));
            ad_v[i]  = $urandom;
            bus.req_i[2*i +: 2]       = req_v[i];
            bus.len_i[2*i +: 2]       = len_v[i];
            bus.cmd_i[3*i +: 3]       = cmd_v[i];
            bus.addrdata_i[DW*i +: DW] = ad_v[i];
        end
    endtask

    // Pick highest level; among equals, the nearest agent after the last winner.
    task automatic model_step();
        int maxl;
        int best;
        int bestd;
        int d;
        if (rst) begin
            m_busy = 0; m_pos = 0; m_owner = 0; m_len = 0; m_last = N - 1;
        end else if (!m_busy || m_pos == m_len + 1) begin
            maxl = 0;
            for (int i = 0; i < N; i++) if (int'(req_v[i]) > maxl) maxl = int'(req_v[i]);
            if (maxl == 0) begin
                m_busy = 0; m_pos = 0; m_owner = 0; m_len = 0;
            end else begin
                best = -1; bestd = N + 1;
                for (int i = 0; i < N; i++) begin
                    if (int'(req_v[i]) == maxl) begin
                        d = (i - m_last + N) % N;
                        if (d == 0) d = N;
                        if (d < bestd) begin bestd = d; best = i; end
                    end
                end
                m_busy = 1; m_owner = best; m_len = int'(len_v[best]);
                m_pos = 0; m_last = best;
            end
        end else begin
            m_pos++;
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        eg = m_busy ? (N'(1) << m_owner) : '0;
        check("gnt",      64'(bus.gnt_o),      64'(eg));
        check("owner",    64'(bus.owner_o),    m_busy ? 64'(m_owner) : 64'd0);
        check("busy",     64'(bus.busy_o),     64'(m_busy));
        check("phase",    64'(bus.phase_o),    64'(m_busy && m_pos != 0));
        check("cmd",      64'(bus.cmd_o),      m_busy ? 64'(cmd_v[m_owner]) : 64'd0);
        check("lenout",   64'(bus.lenout_o),   m_busy ? 64'(m_len) : 64'd0);
        check("addrdata", 64'(bus.addrdata_o), m_busy ? 64'(ad_v[m_owner]) : 64'd0);
        if (bus.busy_o === 1'b1 && bus.phase_o === 1'b0) dut_grants.push_back(int'(bus.owner_o));
    endtask

    task automatic cycle();
        drive();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin req_v[i] = 2'b00; len_v[i] = 2'b00; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    int exp_rr[5] = '{0, 1, 2, 3, 0};

    initial begin
        n_assert = 0;
        n_fail   = 0;
        m_busy = 0; m_owner = 0; m_len = 0; m_pos = 0; m_last = N - 1;
        clear_reqs();

        // 1: reset then idle
        do_reset();
        for (int c = 0; c < 20; c++) begin
            cycle();
            check("t1_gnt", 64'(bus.gnt_o), 64'd0);
            check("t1_busy", 64'(bus.busy_o), 64'd0);
            check("t1_addrdata", 64'(bus.addrdata_o), 64'd0);
        end

        // 2: single agent 2, high priority, len 3
        req_v[2] = 2'b11; len_v[2] = 2'd3;
        cycle();
        check("t2_gnt", 64'(bus.gnt_o), 64'h4);
        check("t2_phase_addr", 64'(bus.phase_o), 64'd0);
        req_v[2] = 2'b00;
        for (int c = 0; c < 4; c++) begin
            cycle();
            check("t2_phase_data", 64'(bus.phase_o), 64'd1);
            check("t2_addrdata", 64'(bus.addrdata_o), 64'(ad_v[2]));
        end
        cycle();
        check("t2_idle", 64'(bus.busy_o), 64'd0);

        // 3: priority, agent 3 (mid) beats agent 0 (low)
        req_v[0] = 2'b01; len_v[0] = 2'd0;
        req_v[3] = 2'b10; len_v[3] = 2'd1;
        cycle();
        check("t3_first", 64'(bus.owner_o), 64'd3);
        req_v[3] = 2'b00;
        cycle();
        cycle();
        check("t3_still3", 64'(bus.owner_o), 64'd3);
        cycle();
        check("t3_then0", 64'(bus.owner_o), 64'd0);
        req_v[0] = 2'b00;
        cycle();
        cycle();

        // 4: round-robin among four high bidders, len 0, back to back
        clear_reqs();
        do_reset();
        dut_grants.delete();
        for (int i = 0; i < N; i++) req_v[i] = 2'b11;
        for (int c = 0; c < 10; c++) begin
            cycle();
            check("t4_busy", 64'(bus.busy_o), 64'd1);
        end
        clear_reqs();
        check("t4_count", 64'(dut_grants.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            check("t4_order", 64'(k < dut_grants.size() ? dut_grants[k] : -1), 64'(exp_rr[k]));
        end
        cycle();
        cycle();

        // 5: reset during data beat 1 aborts; rr pointer returns to N-1
        req_v[1] = 2'b10; len_v[1] = 2'd3;
        cycle();
        req_v[1] = 2'b00;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        check("t5_gnt", 64'(bus.gnt_o), 64'd0);
        check("t5_busy", 64'(bus.busy_o), 64'd0);
        rst = 1'b0;
        req_v[1] = 2'b01; req_v[3] = 2'b01;
        cycle();
        check("t5_lowest", 64'(bus.owner_o), 64'd1);
        clear_reqs();
        for (int c = 0; c < 8; c++) cycle();

        // 6: owner drops request and changes len mid-burst
        req_v[0] = 2'b11; len_v[0] = 2'd2;
        cycle();
        req_v[0] = 2'b00; len_v[0] = 2'd0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("t6_lenout", 64'(bus.lenout_o), 64'd2);
            check("t6_busy", 64'(bus.busy_o), 64'd1);
        end
        cycle();
        check("t6_done", 64'(bus.busy_o), 64'd0);

        // Random traffic with occasional reset
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    req_v[i] = 2'($urandom_range(0, 3));
                    len_v[i] = 2'($urandom_range(0, 3));
                end
            end
            rst = ($urandom_range(0, 79) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
